// File: rtl/dds_phase_ctrl_pkg.sv
// dds_pkg: shared definitions for the DDS phase controller.
//   - default widths for type, amplitude, tuning word, offset, accumulator, address
//   - controller state encoding (IDLE / RUN / PENDING)
//   - param_rec_t: one parameter set, used for both shadow and active registers
package dds_pkg;

  localparam int DEF_BN_ST  = 2;
  localparam int DEF_BN_A   = 11;
  localparam int DEF_BN_F   = 15;
  localparam int DEF_BN_O   = 12;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_ADDR_W = 10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  typedef struct packed {
    logic [DEF_BN_ST-1:0] sig_type;
    logic [DEF_BN_F-1:0]  freq;
    logic [DEF_BN_A-1:0]  amp;
    logic [DEF_BN_O-1:0]  offset;
  } param_rec_t;

  function automatic param_rec_t pack_params(
    input logic [DEF_BN_ST-1:0] sig_type,
    input logic [DEF_BN_F-1:0]  freq,
    input logic [DEF_BN_A-1:0]  amp,
    input logic [DEF_BN_O-1:0]  offset
  );
    param_rec_t rec;
    rec.sig_type = sig_type;
    rec.freq     = freq;
    rec.amp      = amp;
    rec.offset   = offset;
    return rec;
  endfunction

endpackage

// File: rtl/dds_phase_ctrl_phase_acc.sv
// phase_acc: registered DDS phase accumulator.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en        - advance the accumulator by ftw this cycle
//   clr       - force the accumulator to zero (wins over en)
//   ftw       - tuning word, already zero-extended to ACC_W
//   addr      - top ADDR_W bits of the accumulator (ROM phase address)
//   wrap      - carry out of acc + ftw, i.e. the next enabled edge rolls over
module phase_acc #(
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [ACC_W-1:0]  ftw,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // One extra bit on the add exposes the modulo-2^ACC_W rollover as a carry.
  assign sum  = {1'b0, acc} + {1'b0, ftw};
  assign wrap = sum[ACC_W];
  assign addr = acc[ACC_W-1 -: ADDR_W];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/dds_phase_ctrl.sv
// dds_phase_ctrl: captures parameter sets from the UART config block and runs
// the DDS phase accumulator, switching to a new set only at a phase wrap so no
// waveform period is cut short.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   new_data_flag                     - one-cycle pulse, parameter inputs valid
//   signal_type/frequency/amplitude/offset - requested parameter set
//   phase_addr                        - ROM address, top bits of the accumulator
//   type_out/amp_out/offset_out       - active waveform parameters
//   out_valid                         - high once any configuration is active
//   update_pulse                      - one cycle, on the cycle a new set goes active
// Build option:
//   DDS_AMP_RAMP_EN - amp_out slews 1 LSB per clock toward the applied amplitude
//                     instead of jumping; type and offset still switch at once.
module dds_phase_ctrl #(
  parameter int BN_ST  = dds_pkg::DEF_BN_ST,
  parameter int BN_A   = dds_pkg::DEF_BN_A,
  parameter int BN_F   = dds_pkg::DEF_BN_F,
  parameter int BN_O   = dds_pkg::DEF_BN_O,
  parameter int ACC_W  = dds_pkg::DEF_ACC_W,
  parameter int ADDR_W = dds_pkg::DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_data_flag,
  input  logic [BN_ST-1:0]  signal_type,
  input  logic [BN_F-1:0]   frequency,
  input  logic [BN_A-1:0]   amplitude,
  input  logic [BN_O-1:0]   offset,
  output logic [ADDR_W-1:0] phase_addr,
  output logic [BN_ST-1:0]  type_out,
  output logic [BN_A-1:0]   amp_out,
  output logic [BN_O-1:0]   offset_out,
  output logic              out_valid,
  output logic              update_pulse
);

  import dds_pkg::*;

  logic [1:0] state, state_n;
  param_rec_t active, shadow, shadow_n, in_set, apply_set;
  logic       apply;
  logic       wrap;
  logic [ACC_W-1:0] ftw;

  assign in_set = pack_params(signal_type, frequency, amplitude, offset);
  assign ftw    = {{(ACC_W-BN_F){1'b0}}, active.freq};

  // The accumulator sits at zero in IDLE and runs from the first apply
  // onward; it is never cleared on later applies so phase stays continuous.
  phase_acc #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_phase_acc (
    .clk  (clk),
    .rst  (rst),
    .en   (state != ST_IDLE),
    .clr  (state == ST_IDLE),
    .ftw  (ftw),
    .addr (phase_addr),
    .wrap (wrap)
  );

  // Decide whether a parameter set goes active on this edge and which one.
  // A flag that lands on a wrap edge is applied directly; a queued set is
  // applied at the next wrap, or immediately if the active tuning word is
  // zero (no wrap would ever come). Later flags overwrite the queued set.
  always_comb begin
    apply     = 1'b0;
    apply_set = active;
    state_n   = state;
    shadow_n  = shadow;
    case (state)
      ST_IDLE: begin
        if (new_data_flag) begin
          apply     = 1'b1;
          apply_set = in_set;
          state_n   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (new_data_flag) begin
          if (wrap) begin
            apply     = 1'b1;
            apply_set = in_set;
          end else begin
            shadow_n = in_set;
            state_n  = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (wrap || (active.freq == '0)) begin
          apply     = 1'b1;
          apply_set = new_data_flag ? in_set : shadow;
          state_n   = ST_RUN;
        end else if (new_data_flag) begin
          shadow_n = in_set;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      active       <= '0;
      shadow       <= '0;
      out_valid    <= 1'b0;
      update_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      shadow       <= shadow_n;
      update_pulse <= apply;
      if (apply) begin
        active    <= apply_set;
        out_valid <= 1'b1;
      end
    end
  end

  assign type_out   = active.sig_type;
  assign offset_out = active.offset;

`ifdef DDS_AMP_RAMP_EN
  logic [BN_A-1:0] amp_q;
  logic [BN_A-1:0] amp_tgt;

  // active.amp holds the ramp target; the step toward a freshly applied
  // target already happens on the apply edge itself.
  assign amp_tgt = apply ? apply_set.amp : active.amp;

  always_ff @(posedge clk) begin
    if (rst) begin
      amp_q <= '0;
    end else if (amp_q < amp_tgt) begin
      amp_q <= amp_q + 1'b1;
    end else if (amp_q > amp_tgt) begin
      amp_q <= amp_q - 1'b1;
    end
  end

  assign amp_out = amp_q;
`else
  assign amp_out = active.amp;
`endif

endmodule
